// File: rtl/adder_axi_master_if.sv
// AXI4-Lite bus bundle between the adder initiator and the memory-mapped adder slave.
// The master modport is the initiator side; the slave modport is the responder side.
interface adder_axi_master_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/adder_axi_master.sv
// AXI4-Lite initiator: writes two operands to the adder slave, reads back sum and
// overflow, and reports result/overflow/error to the local command side.
module adder_axi_master #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 8,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OPA       = 8'h00,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OPB       = 8'h04,
  parameter logic [ADDR_WIDTH-1:0] ADDR_SUM       = 8'h08,
  parameter logic [ADDR_WIDTH-1:0] ADDR_OVF       = 8'h0C,
  parameter int                    TIMEOUT_CYCLES = 256
) (
  input  logic                  m1_axi_aclk,
  input  logic                  m1_axi_areset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  overflow,
  output logic                  error,
  adder_axi_master_if.master    m1_axi
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_A, WR_B, RD_SUM, RD_OVF, FIN} state_e;

  state_e                  state_q, state_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                    arvalid_q, arvalid_d, rready_q, rready_d;
  logic                    aw_done_q, aw_done_d, w_done_q, w_done_d, ar_done_q, ar_done_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, opb_q, opb_d, result_q, result_d;
  logic                    busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, err_q, err_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    aw_hs, w_hs, ar_hs, wr_done, rd_done, expired, abort, finish;

  assign aw_hs   = awvalid_q & m1_axi.awready;
  assign w_hs    = wvalid_q & m1_axi.wready;
  assign ar_hs   = arvalid_q & m1_axi.arready;
  // A B response only counts once both AW and W have handshaken (possibly this edge).
  assign wr_done = bready_q & m1_axi.bvalid & (aw_done_q | aw_hs) & (w_done_q | w_hs);
  assign rd_done = rready_q & m1_axi.rvalid & ar_done_q;
  assign expired = (cnt_q == CNT_LAST);

  assign m1_axi.awaddr  = awaddr_q;
  assign m1_axi.awvalid = awvalid_q;
  assign m1_axi.wdata   = wdata_q;
  assign m1_axi.wstrb   = '1;
  assign m1_axi.wvalid  = wvalid_q;
  assign m1_axi.bready  = bready_q;
  assign m1_axi.araddr  = araddr_q;
  assign m1_axi.arvalid = arvalid_q;
  assign m1_axi.rready  = rready_q;

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = ovf_q;
  assign error    = err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d   = state_q;
    awvalid_d = awvalid_q;  wvalid_d = wvalid_q;  bready_d = bready_q;
    arvalid_d = arvalid_q;  rready_d = rready_q;
    aw_done_d = aw_done_q;  w_done_d = w_done_q;  ar_done_d = ar_done_q;
    awaddr_d  = awaddr_q;   araddr_d = araddr_q;
    wdata_d   = wdata_q;    opb_d    = opb_q;     result_d = result_q;
    busy_d    = busy_q;     done_d   = 1'b0;      ovf_d    = ovf_q;     err_d = err_q;
    cnt_d     = cnt_q;
    abort     = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WR_A;
          busy_d    = 1'b1;
          err_d     = 1'b0;
          opb_d     = op_b;
          awaddr_d  = ADDR_OPA;
          wdata_d   = op_a;
          awvalid_d = 1'b1;  wvalid_d = 1'b1;  bready_d = 1'b1;
          aw_done_d = 1'b0;  w_done_d = 1'b0;
          cnt_d     = '0;
        end
      end
      WR_A, WR_B: begin
        if (aw_hs) begin awvalid_d = 1'b0; aw_done_d = 1'b1; end
        if (w_hs)  begin wvalid_d  = 1'b0; w_done_d  = 1'b1; end
        if (wr_done) begin
          if (m1_axi.bresp != 2'b00) err_d = 1'b1;
          cnt_d     = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (state_q == WR_A) begin
            state_d   = WR_B;
            awaddr_d  = ADDR_OPB;
            wdata_d   = opb_q;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            state_d   = RD_SUM;
            bready_d  = 1'b0;
            araddr_d  = ADDR_SUM;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            ar_done_d = 1'b0;
          end
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RD_SUM, RD_OVF: begin
        if (ar_hs) begin arvalid_d = 1'b0; ar_done_d = 1'b1; end
        if (rd_done) begin
          if (m1_axi.rresp != 2'b00) err_d = 1'b1;
          cnt_d     = '0;
          ar_done_d = 1'b0;
          if (state_q == RD_SUM) begin
            state_d   = RD_OVF;
            result_d  = m1_axi.rdata;
            araddr_d  = ADDR_OVF;
            arvalid_d = 1'b1;
          end else begin
            ovf_d    = m1_axi.rdata[0];
            rready_d = 1'b0;
            finish   = 1'b1;
          end
        end else if (expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Timeout abandons the bus entirely; result/overflow keep their last values.
    if (abort) begin
      awvalid_d = 1'b0;  wvalid_d = 1'b0;  bready_d = 1'b0;
      arvalid_d = 1'b0;  rready_d = 1'b0;
      err_d     = 1'b1;
      finish    = 1'b1;
    end
    if (finish) begin
      state_d = FIN;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
  end

  always_ff @(posedge m1_axi_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (m1_axi_areset) begin
      state_q   <= IDLE;
      awvalid_q <= 1'b0;  wvalid_q <= 1'b0;  bready_q <= 1'b0;
      arvalid_q <= 1'b0;  rready_q <= 1'b0;
      aw_done_q <= 1'b0;  w_done_q <= 1'b0;  ar_done_q <= 1'b0;
      awaddr_q  <= '0;    araddr_q <= '0;
      wdata_q   <= '0;    opb_q    <= '0;    result_q  <= '0;
      busy_q    <= 1'b0;  done_q   <= 1'b0;  ovf_q     <= 1'b0;  err_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      awvalid_q <= awvalid_d;  wvalid_q <= wvalid_d;  bready_q <= bready_d;
      arvalid_q <= arvalid_d;  rready_q <= rready_d;
      aw_done_q <= aw_done_d;  w_done_q <= w_done_d;  ar_done_q <= ar_done_d;
      awaddr_q  <= awaddr_d;   araddr_q <= araddr_d;
      wdata_q   <= wdata_d;    opb_q    <= opb_d;     result_q  <= result_d;
      busy_q    <= busy_d;     done_q   <= done_d;    ovf_q     <= ovf_d;     err_q <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_adder_axi_master.sv
// Directed bench for adder_axi_master: a small AXI-Lite adder slave model with
// configurable ready/response delays and error injection, checked against hand values.
module tb_adder_axi_master;

  localparam int DW = 32;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic          busy, done, overflow, error;
  logic [DW-1:0] result;

  adder_axi_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  adder_axi_master #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)
  ) dut (
    .m1_axi_aclk  (clk),
    .m1_axi_areset(areset),
    .start        (start),
    .op_a         (op_a),
    .op_b         (op_b),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .overflow     (overflow),
    .error        (error),
    .m1_axi       (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- slave model ----------------
  int   aw_wait   = 0;
  int   b_wait    = 0;
  logic ar_en     = 1'b1;
  logic r_err_sum = 1'b0;

  int            aw_cnt = 0, b_cnt = 0;
  logic          aw_got = 0, w_got = 0, b_pend = 0;
  logic [AW-1:0] wa = '0;
  logic [DW-1:0] wd = '0;
  logic [DW-1:0] s_opa = '0, s_opb = '0;
  logic          s_bvalid = 0, s_rvalid = 0;
  logic [DW-1:0] s_rdata = '0;
  logic [1:0]    s_rresp = '0;
  logic [DW:0]   s_sum;

  int            wr_cnt = 0, rd_cnt = 0;
  logic [AW-1:0] wr_addr [64];
  logic [DW-1:0] wr_data [64];
  logic [AW-1:0] rd_addr [64];

  logic          aw_hs, w_hs;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;

  assign s_sum       = {1'b0, s_opa} + {1'b0, s_opb};
  assign bus.awready = (aw_cnt >= aw_wait);
  assign bus.wready  = 1'b1;
  assign bus.arready = ar_en;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = 2'b00;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;
  assign aw_hs       = bus.awvalid & bus.awready;
  assign w_hs        = bus.wvalid & bus.wready;
  assign w_a         = aw_hs ? bus.awaddr : wa;
  assign w_d         = w_hs ? bus.wdata : wd;

  always @(posedge clk) begin
    if (areset) begin
      aw_cnt <= 0; aw_got <= 0; w_got <= 0; b_pend <= 0; b_cnt <= 0;
      s_bvalid <= 0; s_rvalid <= 0; s_rresp <= 2'b00;
    end else begin
      if (aw_hs) begin aw_cnt <= 0; aw_got <= 1; wa <= bus.awaddr; end
      else if (bus.awvalid) aw_cnt <= aw_cnt + 1;
      if (w_hs) begin w_got <= 1; wd <= bus.wdata; end
      if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        if (w_a == 8'h00) s_opa <= w_d;
        if (w_a == 8'h04) s_opb <= w_d;
        wr_addr[wr_cnt[5:0]] <= w_a;
        wr_data[wr_cnt[5:0]] <= w_d;
        wr_cnt <= wr_cnt + 1;
        aw_got <= 0;
        w_got  <= 0;
        if (b_wait == 0) s_bvalid <= 1;
        else begin b_pend <= 1; b_cnt <= b_wait; end
      end
      if (b_pend) begin
        b_cnt <= b_cnt - 1;
        if (b_cnt == 1) begin s_bvalid <= 1; b_pend <= 0; end
      end
      if (s_bvalid && bus.bready) s_bvalid <= 0;
      if (bus.arvalid && bus.arready) begin
        rd_addr[rd_cnt[5:0]] <= bus.araddr;
        rd_cnt   <= rd_cnt + 1;
        s_rvalid <= 1;
        s_rdata  <= (bus.araddr == 8'h08) ? s_sum[DW-1:0] :
                    (bus.araddr == 8'h0C) ? {{(DW-1){1'b0}}, s_sum[DW]} : '0;
        s_rresp  <= (r_err_sum && bus.araddr == 8'h08) ? 2'b10 : 2'b00;
      end
      if (s_rvalid && bus.rready) s_rvalid <= 0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Returns at the negedge just after the accepting edge.
  task automatic start_txn(input logic [DW-1:0] a, input logic [DW-1:0] b);
    @(negedge clk);
    start = 1'b1; op_a = a; op_b = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat, output int ar_hi);
    lat = -1;
    ar_hi = 0;
    for (int n = 1; n <= budget; n++) begin
      step();
      if (bus.arvalid) ar_hi++;
      if (done) begin lat = n; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, arh, wb, rb, dcnt, bcnt;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {busy, done, error, overflow, bus.awvalid, bus.wvalid,
                       bus.bready, bus.arvalid, bus.rready}, 9'h0);
    check("rst_result", result, 32'h0);
    check("rst_addr_data", {bus.awaddr, bus.araddr, bus.wdata}, 48'h0);
    check("rst_wstrb", bus.wstrb, 4'hF);
    areset = 1'b0;

    // 1: zero-wait slave, 5 + 7
    wb = wr_cnt; rb = rd_cnt;
    start_txn(32'd5, 32'd7);
    check("t1_busy", busy, 1'b1);
    wait_done(40, lat, arh);
    check("t1_latency", lat, 8);
    check("t1_result", result, 32'd12);
    check("t1_ovf_err_busy", {overflow, error, busy}, 3'b000);
    check("t1_wr_count", wr_cnt - wb, 2);
    check("t1_wr_a", {wr_addr[6'(wb)], wr_data[6'(wb)]}, {8'h00, 32'd5});
    check("t1_wr_b", {wr_addr[6'(wb + 1)], wr_data[6'(wb + 1)]}, {8'h04, 32'd7});
    check("t1_rd_count", rd_cnt - rb, 2);
    check("t1_rd_addrs", {rd_addr[6'(rb)], rd_addr[6'(rb + 1)]}, 16'h080C);
    step();
    check("t1_done_one_cycle", done, 1'b0);

    // 2: wrap-around, slave reports overflow
    start_txn(32'hFFFF_FFFF, 32'd1);
    wait_done(40, lat, arh);
    check("t2_latency", lat, 8);
    check("t2_result", result, 32'h0);
    check("t2_overflow", overflow, 1'b1);
    dcnt = 0;
    for (int i = 0; i < 5; i++) begin step(); if (done) dcnt++; end
    check("t2_single_done", dcnt, 0);

    // 3: awready delayed 3 cycles, wready immediate, B two cycles late
    aw_wait = 3; b_wait = 2;
    start_txn(32'h100, 32'h23);
    for (int k = 1; k <= 3; k++) begin
      step();
      check($sformatf("t3_aw_hold_%0d", k), {bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata},
            {1'b1, 1'b0, 8'h00, 32'h100});
    end
    step();
    check("t3_aw_dropped", bus.awvalid, 1'b0);
    step(); step();
    check("t3_still_wr_a", {bus.awvalid, bus.awaddr}, {1'b0, 8'h00});
    step();
    check("t3_wr_b_after_b", {bus.awvalid, bus.awaddr, bus.wdata}, {1'b1, 8'h04, 32'h23});
    wait_done(80, lat, arh);
    check("t3_done_seen", lat > 0, 1'b1);
    check("t3_result", {result, error}, {32'h123, 1'b0});
    aw_wait = 0; b_wait = 0;

    // 4: SLVERR on the sum read
    r_err_sum = 1'b1;
    rb = rd_cnt;
    start_txn(32'd10, 32'd20);
    wait_done(40, lat, arh);
    check("t4_done_seen", lat, 8);
    check("t4_error", error, 1'b1);
    check("t4_ovf_read_issued", {rd_cnt - rb, 32'(rd_addr[6'(rb + 1)])}, {32'd2, 32'h0C});
    check("t4_result", result, 32'd30);
    r_err_sum = 1'b0;

    // 5: arready never rises -> timeout after 16 cycles
    ar_en = 1'b0;
    start_txn(32'd1, 32'd2);
    check("t5_error_cleared", {error, busy}, 2'b01);
    wait_done(60, lat, arh);
    check("t5_latency", lat, 20);
    check("t5_arvalid_cycles", arh, 16);
    check("t5_bus_idle", {bus.arvalid, bus.rready, bus.bready}, 3'b000);
    check("t5_error", error, 1'b1);
    check("t5_result_held", {result, overflow}, {32'd30, 1'b0});
    ar_en = 1'b1;

    // 6: start while busy is ignored; reset during WR_B
    start_txn(32'h11, 32'h22);
    start = 1'b1; op_a = 32'h99; op_b = 32'h88;
    step();
    start = 1'b0;
    step();
    check("t6_op_b_captured", {bus.awvalid, bus.awaddr, bus.wdata}, {1'b1, 8'h04, 32'h22});
    areset = 1'b1;
    step();
    check("t6_rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    check("t6_rst_busy_done", {busy, done}, 2'b00);
    check("t6_rst_result", result, 32'h0);
    areset = 1'b0;
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("t6_no_done", dcnt, 0);
    check("t6_stays_idle", bcnt, 0);

    // Recovery after reset
    start_txn(32'd3, 32'd4);
    wait_done(40, lat, arh);
    check("t7_latency", lat, 8);
    check("t7_result", {result, overflow, error}, {32'd7, 2'b00});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/adder_axi_master.md
Name: adder_axi_master

Overview:
AXI4-Lite initiator that drives the memory-mapped adder slave on behalf of a local command interface. On a start pulse it writes operand A to offset 0x00 and operand B to offset 0x04, then reads the sum from 0x08 and the overflow flag from 0x0C. It returns sum, overflow and status to the local side. It sits between a local controller or testbench and the adder slave on the m1 AXI-Lite port.

Parameters:
DATA_WIDTH, 32, AXI data width and operand width.
ADDR_WIDTH, 8, AXI address width.
ADDR_OPA, 8'h00, operand A register offset.
ADDR_OPB, 8'h04, operand B register offset.
ADDR_SUM, 8'h08, result register offset.
ADDR_OVF, 8'h0C, overflow register offset.
TIMEOUT_CYCLES, 256, maximum wait cycles per AXI phase before abort.

Ports:
m1_axi_aclk  in  1  single clock; all logic on its rising edge
m1_axi_areset  in  1  synchronous, active-high reset
start  in  1  begin a transaction; sampled only in IDLE
op_a  in  DATA_WIDTH  operand A; captured when start is accepted
op_b  in  DATA_WIDTH  operand B; captured when start is accepted
busy  out  1  high from start acceptance until done
done  out  1  one-cycle completion pulse
result  out  DATA_WIDTH  sum read from ADDR_SUM
overflow  out  1  bit 0 of the data read from ADDR_OVF
error  out  1  non-OKAY response or timeout in the last transaction
m1_axi_awaddr  out  ADDR_WIDTH; m1_axi_awvalid out 1; m1_axi_awready in 1
m1_axi_wdata  out  DATA_WIDTH; m1_axi_wstrb out DATA_WIDTH/8; m1_axi_wvalid out 1; m1_axi_wready in 1
m1_axi_bresp  in  2; m1_axi_bvalid in 1; m1_axi_bready out 1
m1_axi_araddr  out  ADDR_WIDTH; m1_axi_arvalid out 1; m1_axi_arready in 1
m1_axi_rdata  in  DATA_WIDTH; m1_axi_rresp in 2; m1_axi_rvalid in 1; m1_axi_rready out 1

Behaviour:
- Reset, synchronous on the clock edge: every valid and ready output, busy, done, error and overflow go to 0. result, awaddr, araddr and wdata go to 0. wstrb goes to all ones. State goes to IDLE.
- Reset mid-transaction: all AXI valids drop at that edge and no done is produced.
- FSM states: IDLE -> WR_A -> WR_B -> RD_SUM -> RD_OVF -> FIN -> IDLE.
- All outputs are registered.
- IDLE: start=1 captures op_a/op_b, clears error, sets busy, enters WR_A, and drives awvalid=wvalid=bready=1 with awaddr=ADDR_OPA and wdata=op_a. start while busy is ignored.
- Write states: awvalid and wvalid each stay high until their own handshake (valid and ready at an edge). They are independent, in either order or the same cycle. Address and data are stable while valid.
- bready is high throughout the write state. The phase completes at the edge where bvalid and bready are both high and both AW and W have handshaken. A B response arriving before either handshake is ignored.
- WR_A completes into WR_B, which drives ADDR_OPB with op_b. WR_B completes into RD_SUM, which asserts arvalid=rready=1 with araddr=ADDR_SUM.
- Read states: arvalid stays high until the AR handshake. rready stays high and the phase completes on the R handshake after AR.
- RD_SUM latches rdata into result and goes to RD_OVF, which uses ADDR_OVF. RD_OVF latches rdata[0] into overflow and goes to FIN.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. result, overflow and error hold until the next accepted start.
- Response check: bresp or rresp not equal to 2'b00 sets error. The sequence still continues to FIN.
- Timeout: a per-phase counter resets at phase entry and increments each cycle the phase is incomplete. When it reaches TIMEOUT_CYCLES, the block drops all valids and readies, sets error and goes to FIN. result and overflow keep the last latched values.
- Latency with a zero-wait slave (readies high, B/R one cycle after the address handshake): done is high in the cycle after the 8th edge following the edge that accepted start.
- Arithmetic: none internal. overflow is taken as-is from the slave.

Test Plan:
- Zero-wait slave, op_a=5, op_b=7 -> writes 0x00=5 and 0x04=7, reads 0x08 and 0x0C; result=12, overflow=0, error=0, done 8 edges after start.
- op_a=32'hFFFF_FFFF, op_b=1, slave returns sum 0 and ovf 1 -> result=0, overflow=1, single done pulse.
- Slave delays awready 3 cycles while wready is immediate, then BVALID after 2 cycles -> awaddr/wdata stable during the wait, wvalid drops after its handshake, WR_B entered only after B.
- Slave returns rresp=2'b10 on the sum read -> error=1, sequence continues to RD_OVF, done pulses.
- Slave never asserts arready, TIMEOUT_CYCLES=16 -> arvalid drops after 16 cycles, error=1, done=1.
- Reset asserted during WR_B, start pulsed while busy -> all valids 0 at the reset edge, busy=0, no done; a start while busy has no effect on the captured operands.
